s2p_frame_ctrl: RTL and testbench

Framing controller and sequencer for the serial-to-parallel path. It detects a start bit and enables the deserializer for exactly the configured number of data bits. It checks the stop bit, then pushes each good word into a 2-entry output buffer with a valid/ready handshake toward the consumer logic. It also reports framing errors, overruns and a frame count for debug display.

---
 rtl/s2p_pkg.sv | 14 +
 rtl/s2p_frame_ctrl_if.sv | 22 ++
 rtl/s2p_out_fifo.sv | 55 +++++
 rtl/s2p_frame_ctrl.sv | 115 +++++++++++
 tb/tb_s2p_frame_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial-to-parallel framing path.
package s2p_pkg;

  localparam int S2P_WORD_W = 16;
  localparam int S2P_LEN_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2,
    PUSH  = 2'd3
  } s2p_state_e;

endpackage

// File: rtl/s2p_frame_ctrl_if.sv
// Output word handshake between the framing controller and its consumer.
interface s2p_frame_ctrl_if #(
  parameter int WORD_W = 16
);

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/s2p_out_fifo.sv
// Two-entry word buffer; head is presented combinationally and reads as 0 when empty.
module s2p_out_fifo #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [WORD_W-1:0] din_i,
  output logic [WORD_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              accept_o
);

  logic [WORD_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;
  logic              pop_ok;

  assign empty_o  = (occ_q == 2'd0);
  assign full_o   = (occ_q == 2'd2);
  assign pop_ok   = pop_i & ~empty_o;
  // A full buffer still takes a word when the head leaves in the same cycle.
  assign accept_o = push_i & (~full_o | pop_ok);
  assign head_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (accept_o) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (accept_o) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({accept_o, pop_ok})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Start-bit detection, length-bounded deserialisation, stop-bit check and buffered word output.
module s2p_frame_ctrl
  import s2p_pkg::*;
#(
  parameter int WORD_W = S2P_WORD_W,
  parameter int LEN_W  = S2P_LEN_W,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             abort,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_count,
  s2p_frame_ctrl_if.master out_if
);

  s2p_state_e        state_q;
  logic [WORD_W-1:0] shift_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  len_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic [CNT_W-1:0]  frame_count_q;

  logic [LEN_W-1:0]  len_d;
  logic              push_req;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_accept;

  assign len_d = ((cfg_len == '0) || (cfg_len > LEN_W'(WORD_W))) ? LEN_W'(WORD_W) : cfg_len;

  // An abort landing on the push cycle discards the finished word as well.
  assign push_req = (state_q == PUSH) & ~abort;
  assign pop      = out_if.out_valid & out_if.out_ready;

  s2p_out_fifo #(
    .WORD_W(WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (out_if.out_ready),
    .din_i   (shift_q),
    .head_o  (out_if.out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .accept_o(fifo_accept)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= push_req & fifo_full & ~pop;
      if (fifo_accept) begin
        frame_count_q <= frame_count_q + CNT_W'(1);
      end
      if (abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bit_en && serial_in) begin
              shift_q <= '0;
              cnt_q   <= '0;
              len_q   <= len_d;
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            if (bit_en) begin
              shift_q <= {shift_q[WORD_W-2:0], serial_in};
              cnt_q   <= cnt_q + LEN_W'(1);
              if (cnt_q + LEN_W'(1) == len_q) begin
                state_q <= STOP;
              end
            end
          end
          STOP: begin
            if (bit_en) begin
              if (serial_in) begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
              end else begin
                state_q <= PUSH;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_if.out_valid = ~fifo_empty;
  assign busy             = (state_q != IDLE);
  assign frame_err        = frame_err_q;
  assign overrun          = overrun_q;
  assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl: vector table plus directed sequences, words checked through a queue.
module tb_s2p_frame_ctrl;
  import s2p_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       bit_en;
  logic       abort;
  logic [4:0] cfg_len;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic [7:0] frame_count;

  s2p_frame_ctrl_if #(.WORD_W(16)) oif ();

  always #5 clk = ~clk;

  s2p_frame_ctrl #(
    .WORD_W(16),
    .LEN_W (5),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_en     (bit_en),
    .cfg_len    (cfg_len),
    .abort      (abort),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .frame_count(frame_count),
    .out_if     (oif)
  );

  typedef struct {
    logic [4:0]  len;
    logic [15:0] data;
    logic        stop;
    int          gap;
    logic [15:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [7];
  int          checks = 0;
  int          errors = 0;
  int          err_pulses = 0;
  int          ovr_pulses = 0;
  logic [15:0] exp_q [$];
  logic [7:0]  exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input logic [4:0] len);
    return ((len == 5'd0) || (len > 5'd16)) ? 16 : int'(len);
  endfunction

  // Consumer side: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (oif.out_valid && oif.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no word", oif.out_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          $display("pop  word 0x%04h (expected 0x%04h)", oif.out_data, e);
          check("pop_data", 32'(oif.out_data), 32'(e));
        end
      end
      if (!oif.out_valid) check("empty_data_zero", 32'(oif.out_data), 32'h0);
      if (frame_err) err_pulses++;
      if (overrun) ovr_pulses++;
      if (frame_err && overrun) check("err_ovr_exclusive", 32'h1, 32'h0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    tick(gap);
    bit_en    = 1'b1;
    serial_in = b;
    tick(1);
    bit_en    = 1'b0;
    serial_in = 1'b0;
  endtask

  // Returns in the cycle after the stop strobe (the PUSH cycle for a good frame).
  task automatic send_frame(input logic [4:0] len, input logic [4:0] len_after,
                            input logic [15:0] data, input logic stop, input int gap);
    int n;
    n = eff_len(len);
    cfg_len = len;
    send_bit(1'b1, gap);
    cfg_len = len_after;
    for (int i = n - 1; i >= 0; i--) send_bit(data[i], gap);
    send_bit(stop, gap);
    $display("send frame len=%0d bits=%0d data=0x%04h stop=%0b", len, n, data, stop);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_q.delete();
    exp_count = 8'd0;
    tick(1);
  endtask

  initial begin
    int e0;
    int o0;

    vecs[0] = '{5'd8,  16'h00A5, 1'b0, 0, 16'h00A5, 1'b0};
    vecs[1] = '{5'd16, 16'hBEEF, 1'b0, 2, 16'hBEEF, 1'b0};
    vecs[2] = '{5'd0,  16'hBEEF, 1'b0, 2, 16'hBEEF, 1'b0};
    vecs[3] = '{5'd4,  16'h0009, 1'b1, 0, 16'h0000, 1'b1};
    vecs[4] = '{5'd20, 16'h1234, 1'b0, 0, 16'h1234, 1'b0};
    vecs[5] = '{5'd1,  16'h0001, 1'b0, 1, 16'h0001, 1'b0};
    vecs[6] = '{5'd12, 16'h0ABC, 1'b0, 0, 16'h0ABC, 1'b0};

    reset = 1'b1; serial_in = 1'b0; bit_en = 1'b0; abort = 1'b0; cfg_len = 5'd8;
    oif.out_ready = 1'b0;
    exp_count = 8'd0;
    tick(2);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(oif.out_valid), 0);
    check("rst_data", 32'(oif.out_data), 0);
    check("rst_count", 32'(frame_count), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun), 0);
    reset = 1'b0;
    tick(1);

    // Asynchronous reset after 5 of 8 data bits
    send_bit(1'b1, 0);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b0, 0);
    check("midframe_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_valid", 32'(oif.out_valid), 0);
    tick(1);
    reset = 1'b0;
    tick(1);

    send_frame(5'd8, 5'd8, 16'h00A5, 1'b0, 0);
    check("latency_not_yet", 32'(oif.out_valid), 0);
    exp_q.push_back(16'h00A5);
    exp_count++;
    tick(1);
    check("latency_valid", 32'(oif.out_valid), 1);
    check("latency_data", 32'(oif.out_data), 32'h00A5);
    check("first_count", 32'(frame_count), 1);
    oif.out_ready = 1'b1;
    tick(3);
    check("first_drained", exp_q.size(), 0);

    for (int v = 0; v < 7; v++) begin
      e0 = err_pulses;
      send_frame(vecs[v].len, vecs[v].len, vecs[v].data, vecs[v].stop, vecs[v].gap);
      if (vecs[v].exp_err) begin
        check("err_idle_after_stop", 32'(busy), 0);
      end else begin
        exp_q.push_back(vecs[v].exp_word);
        exp_count++;
      end
      tick(3);
      check("vec_err_pulses", err_pulses - e0, 32'(vecs[v].exp_err));
      check("vec_count", 32'(frame_count), 32'(exp_count));
      check("vec_drained", exp_q.size(), 0);
      check("vec_valid_low", 32'(oif.out_valid), 0);
    end

    // cfg_len lowered to 4 right after the start bit: frame stays 16 bits
    send_frame(5'd16, 5'd4, 16'hC3A5, 1'b0, 0);
    exp_q.push_back(16'hC3A5);
    exp_count++;
    tick(3);
    check("midlen_count", 32'(frame_count), 32'(exp_count));
    check("midlen_drained", exp_q.size(), 0);

    // Overrun on third word while the consumer stalls
    do_reset();
    oif.out_ready = 1'b0;
    send_frame(5'd8, 5'd8, 16'h0011, 1'b0, 0); exp_q.push_back(16'h0011); exp_count++; tick(1);
    send_frame(5'd8, 5'd8, 16'h0022, 1'b0, 0); exp_q.push_back(16'h0022); exp_count++; tick(1);
    o0 = ovr_pulses;
    send_frame(5'd8, 5'd8, 16'h0033, 1'b0, 0);
    tick(3);
    check("ovr_pulse", ovr_pulses - o0, 1);
    check("ovr_count", 32'(frame_count), 2);
    oif.out_ready = 1'b1;
    tick(4);
    check("ovr_drained", exp_q.size(), 0);
    check("ovr_valid_low", 32'(oif.out_valid), 0);
    check("ovr_count_after", 32'(frame_count), 2);

    // Full buffer with a pop in the PUSH cycle
    oif.out_ready = 1'b0;
    send_frame(5'd8, 5'd8, 16'h0011, 1'b0, 0); exp_q.push_back(16'h0011); exp_count++; tick(1);
    send_frame(5'd8, 5'd8, 16'h0022, 1'b0, 0); exp_q.push_back(16'h0022); exp_count++; tick(1);
    o0 = ovr_pulses;
    send_frame(5'd8, 5'd8, 16'h0044, 1'b0, 0);
    exp_q.push_back(16'h0044);
    exp_count++;
    oif.out_ready = 1'b1;
    tick(1);
    oif.out_ready = 1'b0;
    tick(2);
    check("popfull_no_ovr", ovr_pulses - o0, 0);
    check("popfull_count", 32'(frame_count), 32'(exp_count));
    check("popfull_left", exp_q.size(), 2);
    send_frame(5'd8, 5'd8, 16'h0055, 1'b0, 0);
    tick(3);
    check("popfull_still_full", ovr_pulses - o0, 1);
    oif.out_ready = 1'b1;
    tick(4);
    check("popfull_drained", exp_q.size(), 0);

    // Abort with a simultaneous strobe after 3 data bits
    cfg_len = 5'd8;
    send_bit(1'b1, 0);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    bit_en = 1'b1; serial_in = 1'b1; abort = 1'b1;
    tick(1);
    bit_en = 1'b0; serial_in = 1'b0; abort = 1'b0;
    check("abort_idle", 32'(busy), 0);
    tick(3);
    check("abort_no_word", 32'(oif.out_valid), 0);
    check("abort_count", 32'(frame_count), 32'(exp_count));
    send_frame(5'd8, 5'd8, 16'h005A, 1'b0, 0); exp_q.push_back(16'h005A); exp_count++;
    tick(3);
    check("after_abort_count", 32'(frame_count), 32'(exp_count));

    // Back-to-back short frames up to the counter wrap
    while (exp_count != 8'hFF) begin
      send_frame(5'd1, 5'd1, 16'h0001, 1'b0, 0);
      exp_q.push_back(16'h0001);
      exp_count++;
      tick(1);
    end
    tick(2);
    check("count_255", 32'(frame_count), 32'hFF);
    send_frame(5'd1, 5'd1, 16'h0000, 1'b0, 0);
    exp_q.push_back(16'h0000);
    exp_count++;
    tick(3);
    check("count_wrap", 32'(frame_count), 0);
    check("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
